// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the EX-stage forwarding / hazard controller.
// Optional perf counters are enabled with FWD_HAZARD_PERF_EN.
package hazard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EX_MEM = 2'b10,
    FWD_MEM_WB = 2'b01
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } stage_tag_t;

  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    BUSY
  } ctrl_state_t;

  typedef struct packed {
    ctrl_state_t state;
    stage_tag_t  idex;
    stage_tag_t  exmem;
    stage_tag_t  memwb;
  } dbg_t;

  localparam stage_tag_t TAG_NONE = '0;

  // x0 is hardwired zero, so a write to it never produces a forwardable value.
  function automatic logic tag_eligible(stage_tag_t t);
    return t.valid && t.reg_write && (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode/EX status in, forward selects and stall/flush controls out.
// Perf counter signals exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_ctrl_if;
  import hazard_pkg::*;

  // id_valid qualifies every id_* field in the same cycle; there is no ready.
  // Back-pressure is stall_if_id: while high the decode slot is re-presented.
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              ex_busy;

  logic [1:0]        forward_A;
  logic [1:0]        forward_B;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              load_use_stall;
  dbg_t              dbg;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]       perf_lu_stalls;
  logic [31:0]       perf_flushes;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
    input  forward_A, forward_B, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, load_use_stall, dbg, perf_lu_stalls, perf_flushes
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
    output forward_A, forward_B, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, load_use_stall, dbg, perf_lu_stalls, perf_flushes
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
    input  forward_A, forward_B, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, load_use_stall, dbg
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
    output forward_A, forward_B, stall_pc, stall_if_id, flush_if_id,
           flush_id_ex, load_use_stall, dbg
  );
`endif

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel_gen.sv
// Per-operand forward select: compares one decode source against the two
// newest shadow tags; the newer (ID/EX) tag wins.
module fwd_sel_gen
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  input  stage_tag_t        idex_i,
  input  stage_tag_t        exmem_i,
  output fwd_sel_t          sel_o
);

  logic unused_load;
  assign unused_load = idex_i.is_load ^ exmem_i.is_load;

  always_comb begin
    sel_o = FWD_REG;
    if (use_i && tag_eligible(idex_i) && (rs_i == idex_i.rd)) begin
      sel_o = FWD_EX_MEM;
    end else if (use_i && tag_eligible(exmem_i) && (rs_i == exmem_i.rd)) begin
      sel_o = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use, branch-flush and busy-freeze control for the
// 5-stage core. Optional perf counters behind FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fwd_hazard_ctrl_if.slave  bus
);

  stage_tag_t  idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
  fwd_sel_t    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t    sel_a, sel_b;
  ctrl_state_t state_q, state_d;
  stage_tag_t  decode_tag;
  logic        busy, branch, lu_hit, lu;

  fwd_sel_gen u_sel_a (
    .rs_i    (bus.id_rs1),
    .use_i   (bus.id_valid && bus.id_use_rs1),
    .idex_i  (idex_q),
    .exmem_i (exmem_q),
    .sel_o   (sel_a)
  );

  fwd_sel_gen u_sel_b (
    .rs_i    (bus.id_rs2),
    .use_i   (bus.id_valid && bus.id_use_rs2),
    .idex_i  (idex_q),
    .exmem_i (exmem_q),
    .sel_o   (sel_b)
  );

  assign busy   = bus.ex_busy;
  assign branch = bus.ex_branch_taken && !busy;
  assign lu_hit = bus.id_valid && idex_q.valid && idex_q.is_load && (idex_q.rd != '0) &&
                  ((bus.id_use_rs1 && (bus.id_rs1 == idex_q.rd)) ||
                   (bus.id_use_rs2 && (bus.id_rs2 == idex_q.rd)));
  // A taken branch kills the dependent instruction, so it overrides load-use.
  assign lu     = lu_hit && !busy && !branch;

  always_comb begin
    decode_tag = TAG_NONE;
    if (bus.id_valid) begin
      decode_tag = '{valid: 1'b1, rd: bus.id_rd,
                     reg_write: bus.id_reg_write, is_load: bus.id_mem_read};
    end
  end

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!busy) begin
      memwb_d = exmem_q;
      exmem_d = idex_q;
      if (branch || lu) begin
        idex_d  = TAG_NONE;
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
      end else begin
        idex_d  = decode_tag;
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (lu) state_d = LU_BUBBLE;
      LU_BUBBLE: state_d = RUN;
      BUSY:      state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (busy) state_d = BUSY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= TAG_NONE;
      exmem_q <= TAG_NONE;
      memwb_q <= TAG_NONE;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      state_q <= RUN;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
    end
  end

  // Controls are combinational, so gate them with reset to drop them at once.
  assign bus.forward_A      = fwd_a_q;
  assign bus.forward_B      = fwd_b_q;
  assign bus.stall_pc       = !reset && (busy || lu);
  assign bus.stall_if_id    = !reset && (busy || lu);
  assign bus.flush_if_id    = !reset && branch;
  assign bus.flush_id_ex    = !reset && (branch || lu);
  assign bus.load_use_stall = !reset && lu;
  assign bus.dbg            = '{state: state_q, idex: idex_q, exmem: exmem_q, memwb: memwb_q};

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu)     lu_cnt_d    = lu_cnt_q + 32'd1;
    if (branch) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.perf_lu_stalls = lu_cnt_q;
  assign bus.perf_flushes   = flush_cnt_q;
`else
`endif

endmodule
